// File: rtl/uart_tx_if.sv
// Byte-request handshake between a sender and the UART transmitter.
// data_valid/tx_ready: a byte moves on a rising sys_clk edge where both are high; tx_ready never waits on data_valid.
`timescale 1ns/1ps
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       tx_ready;

    modport master (
        output data_in,
        output data_valid,
        input  tx_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Bit timing is derived internally from sys_clk; TX and all status outputs are registered.
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       sys_clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       TX,
    output logic       busy,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          tx_r;
    logic          ready_r;
    logic          busy_r;
    logic          done_r;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                // The start bit goes out on the very edge that takes the byte.
                if (bus.data_valid) begin
                    shreg   <= bus.data_in;
                    par_bit <= (^bus.data_in) ^ 1'(PARITY_ODD);
                    tx_r    <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= START;
                end
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                case (state)
                    START: begin
                        tx_r    <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx_r  <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx_r  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            tx_r    <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    PARITY: begin
                        tx_r  <= 1'b1;
                        state <= STOP;
                    end
                    STOP: begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= IDLE;
                    end
                    default: begin
                        tx_r  <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.tx_ready = ready_r;
    assign TX           = tx_r;
    assign busy         = busy_r;
    assign tx_done      = done_r;
    assign dbg_state    = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover no parity, even parity and odd parity.
// Every TX cycle of each frame is compared against a frame built from the byte by the bench.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 4;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- DUTs ----------------
    uart_tx_if ifa ();
    uart_tx_if ifb ();
    uart_tx_if ifc ();

    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic       tx_c, busy_c, done_c;
    logic [2:0] dbg_a, dbg_b, dbg_c;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .bus(ifa.slave),
        .TX(tx_a), .busy(busy_a), .tx_done(done_a), .dbg_state(dbg_a)
    );
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .bus(ifb.slave),
        .TX(tx_b), .busy(busy_b), .tx_done(done_b), .dbg_state(dbg_b)
    );
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .sys_clk(sys_clk), .rst(rst), .bus(ifc.slave),
        .TX(tx_c), .busy(busy_c), .tx_done(done_c), .dbg_state(dbg_c)
    );

    // Driver side: one byte source steered to the selected instance.
    int         sel = 0;
    logic [7:0] din = 8'h00;
    logic       dv  = 1'b0;

    assign ifa.data_in = din;
    assign ifb.data_in = din;
    assign ifc.data_in = din;
    assign ifa.data_valid = dv && (sel == 0);
    assign ifb.data_valid = dv && (sel == 1);
    assign ifc.data_valid = dv && (sel == 2);

    logic tx_s, busy_s, done_s, ready_s;
    always_comb begin
        tx_s = tx_a; busy_s = busy_a; done_s = done_a; ready_s = ifa.tx_ready;
        case (sel)
            1: begin tx_s = tx_b; busy_s = busy_b; done_s = done_b; ready_s = ifb.tx_ready; end
            2: begin tx_s = tx_c; busy_s = busy_c; done_s = done_c; ready_s = ifc.tx_ready; end
            default: ;
        endcase
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line levels, bit 0 first: start, D0..D7, [parity], stop.
    function automatic logic [10:0] build_frame(input logic [7:0] b, input bit pen, input bit podd);
        logic [10:0] f;
        logic        p;
        f = '1;
        p = podd;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            p      = p ^ b[i];
        end
        if (pen) f[9] = p;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a byte, waits (bounded) for tx_ready, returns just after the accept edge.
    task automatic send(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        @(negedge sys_clk);
        din = b;
        dv  = 1'b1;
        while (!ready_s && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        check("ready_before_accept", 32'(ready_s), 32'd1);
        @(posedge sys_clk);
        #1;
        if (!hold) dv = 1'b0;
    endtask

    // Called just after an accept edge; checks every cycle of the frame and the done cycle.
    task automatic check_frame(input string tag, input logic [10:0] exp, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge sys_clk);
                check({tag, "_tx"},    32'(tx_s),    32'(exp[k]));
                check({tag, "_busy"},  32'(busy_s),  32'd1);
                check({tag, "_ready"}, 32'(ready_s), 32'd0);
                check({tag, "_done"},  32'(done_s),  32'd0);
            end
        end
        @(negedge sys_clk);
        check({tag, "_end_done"},  32'(done_s),  32'd1);
        check({tag, "_end_ready"}, 32'(ready_s), 32'd1);
        check({tag, "_end_busy"},  32'(busy_s),  32'd0);
        check({tag, "_end_tx"},    32'(tx_s),    32'd1);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            check({tag, "_tx"},    32'(tx_s),    32'd1);
            check({tag, "_ready"}, 32'(ready_s), 32'd1);
            check({tag, "_busy"},  32'(busy_s),  32'd0);
            check({tag, "_done"},  32'(done_s),  32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;

        // Reset state, valid already high while reset is held.
        sel = 0;
        din = 8'h55;
        dv  = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_tx",    32'(tx_a),         32'd1);
        check("rst_ready", 32'(ifa.tx_ready), 32'd1);
        check("rst_busy",  32'(busy_a),       32'd0);
        check("rst_done",  32'(done_a),       32'd0);
        check("rst_state", 32'(dbg_a),        32'd0);
        dv = 1'b0;
        @(negedge sys_clk);
        rst = 1'b1;
        check_quiet("post_rst", 3);

        // Basic frame, no parity: 0,1,0,1,0,0,1,0,1,1.
        send(8'hA5, 1'b0);
        check("a5_frame_const", 32'(build_frame(8'hA5, 1'b0, 1'b0)), 32'h7A5 << 1 & 32'h7FE);
        check_frame("a5", build_frame(8'hA5, 1'b0, 1'b0), 10);
        @(negedge sys_clk);
        check("a5_done_width", 32'(done_s), 32'd0);

        // Even and odd parity on 8'h07 (three ones).
        sel = 1;
        send(8'h07, 1'b0);
        check_frame("even07", 11'b11_0000_0111_0, 11);
        sel = 2;
        send(8'h07, 1'b0);
        check_frame("odd07", 11'b10_0000_0111_0, 11);
        sel = 1;
        send(8'h03, 1'b0);
        check_frame("even03", 11'b10_0000_0011_0, 11);

        // Back-to-back with data_valid held: stop level spans CPB+1 cycles.
        sel = 0;
        send(8'h00, 1'b1);
        din = 8'hFF;
        check_frame("b2b00", build_frame(8'h00, 1'b0, 1'b0), 10);
        @(posedge sys_clk);
        #1;
        dv = 1'b0;
        check("b2b_accept_tx",    32'(tx_s),    32'd0);
        check("b2b_accept_ready", 32'(ready_s), 32'd0);
        check("b2b_accept_busy",  32'(busy_s),  32'd1);
        check_frame("b2bff", build_frame(8'hFF, 1'b0, 1'b0), 10);
        check_quiet("b2b_tail", 2 * CPB);

        // Mid-frame request is ignored.
        send(8'h96, 1'b0);
        fork
            check_frame("mid96", build_frame(8'h96, 1'b0, 1'b0), 10);
            begin
                repeat (10) @(negedge sys_clk);
                din = 8'h5A;
                dv  = 1'b1;
                check("mid_ready_low", 32'(ready_s), 32'd0);
                @(negedge sys_clk);
                dv = 1'b0;
            end
        join
        check_quiet("mid_tail", 3 * CPB);

        // Reset during D3 drops the frame immediately.
        send(8'hA5, 1'b0);
        repeat (17) @(negedge sys_clk);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_tx",    32'(tx_a),         32'd1);
        check("async_busy",  32'(busy_a),       32'd0);
        check("async_ready", 32'(ifa.tx_ready), 32'd1);
        check("async_state", 32'(dbg_a),        32'd0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;
        check_quiet("after_rst", 2);
        send(8'h3C, 1'b0);
        check_frame("x3c", 11'b11_0011_1100_0, 10);

        // Random bytes through the no-parity instance.
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 1'b0);
            check_frame("rand", build_frame(rb, 1'b0, 1'b0), 10);
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
        $fatal(1);
    end

endmodule
